// File: rtl/pos_add_serial.sv
// pos_add_serial
// Serial unsigned adder. It captures a pair of N_BITS operands and adds
// them CHUNK bits per clock, least significant chunk first. A single carry
// register links one chunk to the next. The full N_BITS+1 bit sum is then
// presented on a valid/ready output handshake.
//
// Parameters
//   N_BITS : operand width. It must be an integer multiple of CHUNK.
//   CHUNK  : bits added per clock cycle, with CHUNK >= 1.
//
// Ports
//   clk       in   sole clock; all state updates on the rising edge
//   rst       in   asynchronous, active-high reset
//   in_valid  in   a/b hold valid operands this cycle
//   in_ready  out  block can accept operands this cycle (IDLE)
//   a, b      in   unsigned operands, N_BITS wide
//   out_valid out  c holds a completed sum (DONE)
//   out_ready in   consumer takes c this cycle
//   c         out  a+b, N_BITS+1 wide; the MSB is the final carry
module pos_add_serial #(
    parameter int N_BITS = 16,
    parameter int CHUNK  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N_BITS-1:0] a,
    input  logic [N_BITS-1:0] b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N_BITS:0]   c
);

    localparam int NCHUNK = N_BITS / CHUNK;
    // The counter is wide enough to count up to NCHUNK. The increment on
    // the last chunk therefore never wraps back to zero.
    localparam int CW = $clog2(NCHUNK + 1);
    localparam logic [CW-1:0]     LAST_K     = CW'(NCHUNK - 1);
    localparam logic [N_BITS-1:0] CHUNK_MASK = N_BITS'({CHUNK{1'b1}});

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t            r_state;
    state_t            w_stateNext;
    logic [N_BITS-1:0] r_a;
    logic [N_BITS-1:0] r_b;
    logic [N_BITS:0]   r_c;
    logic              r_carry;
    logic [CW-1:0]     r_k;

    logic [31:0]       w_base;
    logic [CHUNK-1:0]  w_aChunk;
    logic [CHUNK-1:0]  w_bChunk;
    logic [CHUNK:0]    w_chunkSum;
    logic [N_BITS-1:0] w_laneMask;
    logic [N_BITS-1:0] w_laneData;
    logic              w_lastChunk;

    // Select chunk k of the captured operands. A shift replaces an indexed
    // part-select, so the chunk position can be any runtime value. The
    // slice still lands in the same bit range of the result register.
    assign w_base      = 32'(r_k) * 32'(CHUNK);
    assign w_aChunk    = CHUNK'(r_a >> w_base);
    assign w_bChunk    = CHUNK'(r_b >> w_base);
    assign w_chunkSum  = {1'b0, w_aChunk} + {1'b0, w_bChunk} + {{CHUNK{1'b0}}, r_carry};
    assign w_laneMask  = CHUNK_MASK << w_base;
    assign w_laneData  = N_BITS'(w_chunkSum[CHUNK-1:0]) << w_base;
    assign w_lastChunk = (r_k == LAST_K);

    // State register. Reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state logic. The handshake outputs are decoded from the state
    // alone, so in_valid and out_ready have no combinational path to them.
    always_comb begin
        w_stateNext = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_stateNext = BUSY;
                end
            end
            BUSY: begin
                if (w_lastChunk) begin
                    w_stateNext = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_stateNext = IDLE;
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    // Datapath. Operands are copied in on acceptance, so later changes on
    // a/b have no effect. The result register is only rewritten chunk by
    // chunk while BUSY. It therefore keeps the previous sum through IDLE
    // until the next operation starts overwriting it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_c     <= '0;
            r_carry <= 1'b0;
            r_k     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= 1'b0;
                        r_k     <= '0;
                    end
                end
                BUSY: begin
                    r_c[N_BITS-1:0] <= (r_c[N_BITS-1:0] & ~w_laneMask) | w_laneData;
                    r_carry         <= w_chunkSum[CHUNK];
                    r_k             <= r_k + CW'(1);
                    if (w_lastChunk) begin
                        r_c[N_BITS] <= w_chunkSum[CHUNK];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign c = r_c;

endmodule

// File: tb/tb_pos_add_serial.sv
// tb_pos_add_serial
// Self-checking bench for pos_add_serial.
//   - Main instance (16/4): reset state, a table of operand pairs, output
//     hold under back-pressure, reset abort, and operands ignored while busy.
//   - Wide instance (16/16): single-cycle completion.
//   - One instance per legal (N_BITS, CHUNK) pair, N_BITS in {8,16,32} and
//     CHUNK in {1,2,4,8}. Each runs random operands with random out_ready
//     against plain a+b arithmetic, and checks latency on every transaction.
module tb_pos_add_serial;

    localparam int NTX  = 700;
    localparam int NCFG = 12;

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic rstR = 1'b1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [16:0] c;
    } vec_t;

    // Main instance, N_BITS=16, CHUNK=4
    logic        mValid;
    logic        mReady;
    logic [15:0] mA;
    logic [15:0] mB;
    logic        mOutValid;
    logic        mOutReady;
    logic [16:0] mC;

    pos_add_serial #(.N_BITS(16), .CHUNK(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (mValid),
        .in_ready  (mReady),
        .a         (mA),
        .b         (mB),
        .out_valid (mOutValid),
        .out_ready (mOutReady),
        .c         (mC)
    );

    // Single-chunk instance, N_BITS=16, CHUNK=16
    logic        wValid;
    logic        wReady;
    logic [15:0] wA;
    logic [15:0] wB;
    logic        wOutValid;
    logic        wOutReady;
    logic [16:0] wC;

    pos_add_serial #(.N_BITS(16), .CHUNK(16)) dutWide (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (wValid),
        .in_ready  (wReady),
        .a         (wA),
        .b         (wB),
        .out_valid (wOutValid),
        .out_ready (wOutReady),
        .c         (wC)
    );

    logic [NCFG-1:0] doneVec;

    // A single place where every comparison is counted and reported.
    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Runs one full transaction on the main instance. It returns the sum
    // seen when out_valid rises, the number of edges from acceptance, and
    // how many post-edge samples showed in_ready high while in flight.
    task automatic applyStimulus(input logic [15:0] opA, input logic [15:0] opB,
                                 output logic [16:0] res, output int lat, output int rdyHigh);
        lat     = 0;
        rdyHigh = 0;
        @(negedge clk);
        checkOutput("acceptReady", 64'(mReady), 64'(1));
        mValid = 1'b1;
        mA     = opA;
        mB     = opB;
        @(posedge clk); #1;
        if (mReady) rdyHigh++;
        while (!mOutValid && lat < 20) begin
            @(negedge clk);
            mValid = 1'b0;
            mA     = ~opA;
            mB     = opB ^ 16'h5A5A;
            @(posedge clk); #1;
            lat++;
            if (mReady) rdyHigh++;
        end
        res = mC;
        @(negedge clk);
        mOutReady = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        mOutReady = 1'b0;
    endtask

    // Random traffic, one instance per legal configuration
    generate
        for (genvar g = 0; g < NCFG; g++) begin : gCfg
            localparam int NB = 8 << (g / 4);
            localparam int CH = 1 << (g % 4);
            localparam int NC = NB / CH;

            logic          inValid;
            logic          inReady;
            logic [NB-1:0] opA;
            logic [NB-1:0] opB;
            logic          outValid;
            logic          outReady;
            logic [NB:0]   sum;
            logic          done = 1'b0;

            pos_add_serial #(.N_BITS(NB), .CHUNK(CH)) dutRand (
                .clk       (clk),
                .rst       (rstR),
                .in_valid  (inValid),
                .in_ready  (inReady),
                .a         (opA),
                .b         (opB),
                .out_valid (outValid),
                .out_ready (outReady),
                .c         (sum)
            );

            assign doneVec[g] = done;

            // Each transaction is checked against a+b of the pair offered
            // at the accepting edge. in_valid and the operands are scrambled
            // while busy and done, which must have no effect on the result.
            initial begin : randTest
                logic [NB-1:0] ra;
                logic [NB-1:0] rb;
                logic [NB:0]   expSum;
                int            lat;
                int            tries;
                string         tag;
                tag      = $sformatf("rand%0dx%0d", NB, CH);
                inValid  = 1'b0;
                outReady = 1'b0;
                opA      = '0;
                opB      = '0;
                @(negedge clk);
                while (rstR) @(negedge clk);
                for (int t = 0; t < NTX; t++) begin
                    repeat ($urandom_range(0, 1)) @(negedge clk);
                    ra = NB'($urandom);
                    rb = NB'($urandom);
                    if ($urandom_range(0, 15) == 0) begin
                        ra = '1;
                        rb = '1;
                    end
                    expSum = {1'b0, ra} + {1'b0, rb};
                    checkOutput({tag, ".idleReady"}, 64'(inReady), 64'(1));
                    inValid = 1'b1;
                    opA     = ra;
                    opB     = rb;
                    @(posedge clk); #1;
                    lat = 0;
                    while (!outValid && lat < NC + 4) begin
                        @(negedge clk);
                        inValid  = 1'($urandom_range(0, 1));
                        opA      = NB'($urandom);
                        opB      = NB'($urandom);
                        outReady = 1'($urandom_range(0, 1));
                        @(posedge clk); #1;
                        lat++;
                        if (!outValid) begin
                            checkOutput({tag, ".busyReady"}, 64'(inReady), 64'(0));
                        end
                    end
                    checkOutput({tag, ".latency"}, 64'(lat), 64'(NC));
                    tries = 0;
                    do begin
                        @(negedge clk);
                        checkOutput({tag, ".c"}, 64'(sum), 64'(expSum));
                        checkOutput({tag, ".doneValid"}, 64'(outValid), 64'(1));
                        checkOutput({tag, ".doneReady"}, 64'(inReady), 64'(0));
                        outReady = (tries >= 6) ? 1'b1 : 1'($urandom_range(0, 1));
                        inValid  = 1'($urandom_range(0, 1));
                        tries++;
                        @(posedge clk); #1;
                    end while (!outReady);
                    @(negedge clk);
                    outReady = 1'b0;
                    inValid  = 1'b0;
                    checkOutput({tag, ".idleValid"}, 64'(outValid), 64'(0));
                    checkOutput({tag, ".idleHoldC"}, 64'(sum), 64'(expSum));
                end
                done = 1'b1;
            end
        end
    endgenerate

    // Directed sequence on the main and single-chunk instances, then the
    // wait for the random instances and the summary.
    initial begin : mainSeq
        vec_t        vecs[8];
        vec_t        wVecs[3];
        logic [16:0] res;
        int          lat;
        int          rh;
        int          guard;
        logic        sawValid;

        mValid    = 1'b0;
        mA        = '0;
        mB        = '0;
        mOutReady = 1'b0;
        wValid    = 1'b0;
        wA        = '0;
        wB        = '0;
        wOutReady = 1'b0;

        vecs[0] = '{16'h0000, 16'h0000, 17'h00000};
        vecs[1] = '{16'hFFFF, 16'h0001, 17'h10000};
        vecs[2] = '{16'h1234, 16'h4321, 17'h05555};
        vecs[3] = '{16'hFFFF, 16'hFFFF, 17'h1FFFE};
        vecs[4] = '{16'h8000, 16'h8000, 17'h10000};
        vecs[5] = '{16'h0F0F, 16'hF0F1, 17'h10000};
        vecs[6] = '{16'h00FF, 16'h0001, 17'h00100};
        vecs[7] = '{16'hABCD, 16'h1111, 17'h0BCDE};

        wVecs[0] = '{16'h8000, 16'h8000, 17'h10000};
        wVecs[1] = '{16'hFFFF, 16'hFFFF, 17'h1FFFE};
        wVecs[2] = '{16'h1234, 16'h0001, 17'h01235};

        // Reset state, sampled before any clock edge
        #2;
        checkOutput("resetC", 64'(mC), 64'(0));
        checkOutput("resetInReady", 64'(mReady), 64'(1));
        checkOutput("resetOutValid", 64'(mOutValid), 64'(0));
        checkOutput("resetWideC", 64'(wC), 64'(0));
        @(negedge clk);
        @(negedge clk);
        rst  = 1'b0;
        rstR = 1'b0;

        // Table of operand pairs: sum, 4-edge latency, in_ready low in flight
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, res, lat, rh);
            checkOutput($sformatf("vec%0d.c", i), 64'(res), 64'(vecs[i].c));
            checkOutput($sformatf("vec%0d.latency", i), 64'(lat), 64'(4));
            checkOutput($sformatf("vec%0d.busyReady", i), 64'(rh), 64'(0));
        end

        // Result held under back-pressure for ten cycles
        @(negedge clk);
        mValid = 1'b1;
        mA     = 16'h1234;
        mB     = 16'h4321;
        @(posedge clk); #1;
        @(negedge clk);
        mValid = 1'b0;
        guard  = 0;
        while (!mOutValid && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        checkOutput("holdReached", 64'(mOutValid), 64'(1));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("holdValid", 64'(mOutValid), 64'(1));
            checkOutput("holdC", 64'(mC), 64'(17'h05555));
            @(posedge clk);
        end
        @(negedge clk);
        mOutReady = 1'b1;
        @(posedge clk); #1;
        checkOutput("releaseReady", 64'(mReady), 64'(1));
        checkOutput("releaseValid", 64'(mOutValid), 64'(0));
        checkOutput("releaseHoldC", 64'(mC), 64'(17'h05555));
        @(negedge clk);
        mOutReady = 1'b0;

        // Reset two edges into an operation aborts it
        @(negedge clk);
        mValid = 1'b1;
        mA     = 16'hFFFF;
        mB     = 16'hFFFF;
        @(posedge clk); #1;
        @(negedge clk);
        mValid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("abortAsyncC", 64'(mC), 64'(0));
        checkOutput("abortAsyncReady", 64'(mReady), 64'(1));
        checkOutput("abortAsyncValid", 64'(mOutValid), 64'(0));
        @(negedge clk);
        rst      = 1'b0;
        sawValid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (mOutValid) sawValid = 1'b1;
        end
        checkOutput("abortNoValid", 64'(sawValid), 64'(0));
        checkOutput("abortC", 64'(mC), 64'(0));
        checkOutput("abortReady", 64'(mReady), 64'(1));
        applyStimulus(16'h0002, 16'h0003, res, lat, rh);
        checkOutput("postAbort.c", 64'(res), 64'(17'h00005));
        checkOutput("postAbort.latency", 64'(lat), 64'(4));

        // in_valid held high while busy, operands changing every cycle
        @(negedge clk);
        mValid = 1'b1;
        mA     = 16'h0F00;
        mB     = 16'h00F0;
        @(posedge clk); #1;
        guard = 0;
        while (!mOutValid && guard < 20) begin
            @(negedge clk);
            mA = 16'($urandom);
            mB = 16'($urandom);
            @(posedge clk); #1;
            guard++;
        end
        checkOutput("ignore.latency", 64'(guard), 64'(4));
        checkOutput("ignore.c", 64'(mC), 64'(17'h00FF0));
        @(negedge clk);
        mValid    = 1'b0;
        mOutReady = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        mOutReady = 1'b0;
        sawValid  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (mOutValid) sawValid = 1'b1;
        end
        checkOutput("ignore.singleOp", 64'(sawValid), 64'(0));

        // Single-chunk configuration completes one edge after acceptance
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            wValid = 1'b1;
            wA     = wVecs[i].a;
            wB     = wVecs[i].b;
            @(posedge clk); #1;
            @(negedge clk);
            wValid = 1'b0;
            lat    = 0;
            while (!wOutValid && lat < 10) begin
                @(posedge clk); #1;
                lat++;
            end
            checkOutput($sformatf("wide%0d.latency", i), 64'(lat), 64'(1));
            checkOutput($sformatf("wide%0d.c", i), 64'(wC), 64'(wVecs[i].c));
            @(negedge clk);
            wOutReady = 1'b1;
            @(posedge clk); #1;
            @(negedge clk);
            wOutReady = 1'b0;
        end

        // Wait, within a cycle budget, for every random instance to finish
        guard = 0;
        while (!(&doneVec) && guard < 60000) begin
            @(posedge clk);
            guard++;
        end
        checkOutput("randomDone", 64'(&doneVec), 64'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
